// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Writeback sources, issue tracking and register-file write bus
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] busy;
  logic        stall_wb;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, iss_valid, iss_addr,
    input  b_ready, rf_wr, rf_addr, rf_data, busy, stall_wb
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, iss_valid, iss_addr,
    output b_ready, rf_wr, rf_addr, rf_data, busy, stall_wb
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares one register-file write port between pipeline WB (A)
//               and a FIFO-buffered long-latency result stream (B).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  regfile_wb_arbiter_if.slave     bus
);

  localparam int c_ptr_w  = $clog2(DEPTH);
  localparam int c_cnt_w  = $clog2(DEPTH + 1);
  localparam int c_wait_w = $clog2(MAX_WAIT + 1);
  localparam logic [c_cnt_w-1:0]  c_depth    = c_cnt_w'(DEPTH);
  localparam logic [c_wait_w-1:0] c_max_wait = c_wait_w'(MAX_WAIT);

  logic [4:0]          fifo_addr_q [DEPTH];
  logic [31:0]         fifo_data_q [DEPTH];
  logic [c_ptr_w-1:0]  rd_ptr_q, wr_ptr_q;
  logic [c_cnt_w-1:0]  count_q, count_d;
  logic [31:0]         busy_q, busy_d;
  logic [c_wait_w-1:0] wait_q, wait_d;
  logic                stall_q, stall_d;

  logic        w_empty, w_a_win, w_pop, w_push, w_b_commit, w_b_ready;
  logic [4:0]  w_head_addr;
  logic [31:0] w_head_data;

  assign w_head_addr = fifo_addr_q[rd_ptr_q];
  assign w_head_data = fifo_data_q[rd_ptr_q];

  always_comb begin
    w_empty     = (count_q == '0);
    w_a_win     = bus.a_valid && (bus.a_addr != 5'd0) && !rst;
    w_pop       = !w_a_win && !w_empty && !rst;
    // Heads addressed to x0 still pop, they just never reach the register file.
    w_b_commit  = w_pop && (w_head_addr != 5'd0);
    w_b_ready   = (count_q < c_depth) && !rst;
    w_push      = bus.b_valid && w_b_ready;

    bus.rf_wr   = 1'b0;
    bus.rf_addr = 5'd0;
    bus.rf_data = 32'd0;
    if (w_a_win) begin
      bus.rf_wr   = 1'b1;
      bus.rf_addr = bus.a_addr;
      bus.rf_data = bus.a_data;
    end else if (w_b_commit) begin
      bus.rf_wr   = 1'b1;
      bus.rf_addr = w_head_addr;
      bus.rf_data = w_head_data;
    end
    bus.b_ready  = w_b_ready;
    bus.busy     = busy_q;
    bus.stall_wb = stall_q;
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear first so a same-cycle issue to the same register wins.
    busy_d = busy_q;
    if (w_b_commit) begin
      busy_d[w_head_addr] = 1'b0;
    end
    if (bus.iss_valid) begin
      busy_d[bus.iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;

    wait_d = wait_q;
    if (w_empty || w_pop) begin
      wait_d = '0;
    end else if (wait_q < c_max_wait) begin
      wait_d = wait_q + 1'b1;
    end
    stall_d = (wait_d >= c_max_wait);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      wait_q   <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (w_push) begin
        fifo_addr_q[wr_ptr_q] <= bus.b_addr;
        fifo_data_q[wr_ptr_q] <= bus.b_data;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      busy_q  <= busy_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Scoreboard bench for regfile_wb_arbiter against a queue model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int c_depth    = 2;
  localparam int c_max_wait = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus_if ();

  regfile_wb_arbiter #(.DEPTH(c_depth), .MAX_WAIT(c_max_wait)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rdy;
    logic [31:0] busy;
    logic        stall;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } bent_t;

  exp_t        expq [$];
  bent_t       mq   [$];
  logic [31:0] mbusy  = 32'd0;
  int          mwait  = 0;
  logic        mstall = 1'b0;
  int          total  = 0;
  int          bad    = 0;
  int          cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("rf_wr",    {31'd0, bus_if.rf_wr},    {31'd0, e.wr});
      if (e.wr) begin
        chk("rf_addr", {27'd0, bus_if.rf_addr}, {27'd0, e.addr});
        chk("rf_data", bus_if.rf_data,          e.data);
      end
      chk("b_ready",  {31'd0, bus_if.b_ready},  {31'd0, e.rdy});
      chk("busy",     bus_if.busy,              e.busy);
      chk("stall_wb", {31'd0, bus_if.stall_wb}, {31'd0, e.stall});
      cyc++;
    end
  end

  // Drive one cycle, record the expected response, then advance the model.
  task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic iv, input logic [4:0] ia);
    exp_t  e;
    bent_t h;
    bent_t n;
    logic  pop;
    logic  push;
    int    pre_size;
    @(posedge clk);
    #1;
    rst              = r;
    bus_if.a_valid   = av;
    bus_if.a_addr    = aa;
    bus_if.a_data    = ad;
    bus_if.b_valid   = bv;
    bus_if.b_addr    = ba;
    bus_if.b_data    = bd;
    bus_if.iss_valid = iv;
    bus_if.iss_addr  = ia;

    pre_size = mq.size();
    pop      = 1'b0;
    e.wr     = 1'b0;
    e.addr   = 5'd0;
    e.data   = 32'd0;
    e.rdy    = !r && (pre_size < c_depth);
    e.busy   = mbusy;
    e.stall  = mstall;
    if (!r) begin
      if (av && aa != 5'd0) begin
        e.wr   = 1'b1;
        e.addr = aa;
        e.data = ad;
      end else if (pre_size > 0) begin
        h   = mq[0];
        pop = 1'b1;
        if (h.addr != 5'd0) begin
          e.wr   = 1'b1;
          e.addr = h.addr;
          e.data = h.data;
        end
      end
    end
    expq.push_back(e);

    if (r) begin
      mq.delete();
      mbusy  = 32'd0;
      mwait  = 0;
      mstall = 1'b0;
    end else begin
      push = bv && (pre_size < c_depth);
      if (pop && h.addr != 5'd0) mbusy[h.addr] = 1'b0;
      if (iv && ia != 5'd0)      mbusy[ia]     = 1'b1;
      if (pre_size == 0 || pop) mwait = 0;
      else if (mwait < c_max_wait) mwait = mwait + 1;
      mstall = (mwait >= c_max_wait);
      if (pop) void'(mq.pop_front());
      if (push) begin
        n.addr = ba;
        n.data = bd;
        mq.push_back(n);
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
  endtask

  initial begin
    bus_if.a_valid   = 1'b0;
    bus_if.a_addr    = 5'd0;
    bus_if.a_data    = 32'd0;
    bus_if.b_valid   = 1'b1;
    bus_if.b_addr    = 5'd4;
    bus_if.b_data    = 32'h55;
    bus_if.iss_valid = 1'b0;
    bus_if.iss_addr  = 5'd0;

    // Reset held with B offering data
    step(1, 0, 5'd0, 32'd0, 1, 5'd4, 32'h55, 0, 5'd0);
    step(1, 0, 5'd0, 32'd0, 1, 5'd4, 32'h55, 0, 5'd0);

    // A only, including a write to x0
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0);
    step(0, 1, 5'd0, 32'h1234, 0, 5'd0, 32'd0, 0, 5'd0);

    // Contention, then B drains
    step(0, 1, 5'd3, 32'hA3, 1, 5'd7, 32'h11, 0, 5'd0);
    idle();
    idle();

    // Fill, refused push when full, in-order drain
    step(0, 1, 5'd3, 32'h1, 1, 5'd8,  32'h88, 0, 5'd0);
    step(0, 1, 5'd4, 32'h2, 1, 5'd9,  32'h99, 0, 5'd0);
    step(0, 1, 5'd4, 32'h3, 1, 5'd10, 32'hAA, 0, 5'd0);
    repeat (3) idle();

    // Starvation and release
    step(0, 1, 5'd6, 32'h6, 1, 5'd11, 32'hB, 0, 5'd0);
    for (int i = 0; i < 6; i++) step(0, 1, 5'd6, 32'h60 + i, 0, 5'd0, 32'd0, 0, 5'd0);
    repeat (2) idle();

    // Scoreboard set, clear, simultaneous set/clear, x0 issue
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd12);
    step(0, 0, 5'd0, 32'd0, 1, 5'd12, 32'hC, 0, 5'd0);
    idle();
    idle();
    step(0, 0, 5'd0, 32'd0, 1, 5'd12, 32'hCC, 0, 5'd0);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd12);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd0);
    idle();

    // B result to x0 is discarded
    step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hF0, 0, 5'd0);
    idle();

    // Reset with queued entries and busy bits
    step(0, 1, 5'd2, 32'h2, 1, 5'd13, 32'hD, 1, 5'd13);
    step(0, 1, 5'd2, 32'h2, 1, 5'd14, 32'hE, 1, 5'd14);
    step(1, 1, 5'd2, 32'h2, 0, 5'd0, 32'd0, 0, 5'd0);
    idle();
    idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0),
           ($urandom_range(9) < 6), 5'($urandom_range(31)), $urandom,
           ($urandom_range(1) == 1), 5'($urandom_range(31)), $urandom,
           ($urandom_range(9) < 3), 5'($urandom_range(31)));
    end
    idle();

    @(negedge clk);
    #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
